io_switch_debounce: RTL and testbench



---
 rtl/io_switch_debounce.sv | 135 +++++++++++++
 tb/tb_io_switch_debounce.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/io_switch_debounce.sv
// io_switch_debounce
// Front-end conditioner for the slide switches and the push-button.
// Each raw pin (sw[9:0] and key) is a separate channel. Every channel is
// brought into the io_clk domain through two flops and then debounced by a
// per-channel stability counter. A debounced key press toggles sub_mode.
//
// Build option: define IO_DEBOUNCE_EN to enable the stability counters.
// Without it, the counters are removed and each stable bit follows its
// synchroniser output on every edge. DB_CYCLES and CNT_W then have no effect.

module io_switch_debounce #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned CNT_W     = 19
) (
  input  logic        io_clk,
  input  logic        resetn,
  input  logic [9:0]  sw,
  input  logic        key,
  output logic [31:0] in_port0,
  output logic [31:0] in_port1,
  output logic [31:0] in_port_sub
);

  // Channel map: bits 9..0 are the switches and bit 10 is the key.
  localparam int unsigned    NCH     = 11;
  localparam int unsigned    KEY_IDX = 10;
  // Switches idle low. The key is active-low, so it idles high (released).
  localparam logic [NCH-1:0] RST_VAL = {1'b1, 10'b0};

  // Reject illegal parameter sets when the design is elaborated.
  if (DB_CYCLES < 2 || CNT_W < 1 ||
      (CNT_W < 32 && (64'd1 << CNT_W) < 64'(DB_CYCLES))) begin : g_bad_params
    $error("io_switch_debounce: DB_CYCLES must be >= 2 and fit in CNT_W bits");
  end

  logic [NCH-1:0] raw;
  logic [NCH-1:0] s1;
  logic [NCH-1:0] s2;
  logic [NCH-1:0] stable;
  logic [NCH-1:0] stable_nxt;
  logic           sub_mode;
  logic           press;

  assign raw = {key, sw};

  // Two-flop synchroniser for every channel.
  // NOTE: sequential state always uses non-blocking (<=) assignments. The
  // s2 <= s1 update then reads the value s1 held before this edge, which
  // gives a real two-stage chain instead of one collapsed flop.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt     [NCH];
  logic [CNT_W-1:0] cnt_nxt [NCH];

  // Per-channel stability count.
  // A mismatch must persist for DB_CYCLES consecutive edges before it is
  // accepted. Any return to the stable level clears the count, so a bounce
  // restarts the full window. The count stops at CNT_MAX and never wraps.
  // NOTE: every signal written here gets a default value first. This means
  // that no path through the loop leaves a value unassigned, so no latch
  // is inferred.
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = cnt;
    for (int i = 0; i < NCH; i++) begin
      if (s2[i] == stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        stable_nxt[i] = s2[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  // Counter registers. A mid-count reset clears them immediately.
  // NOTE: this counter array is reset explicitly, entry by entry. Each
  // entry is a small discrete register, not a RAM macro, and after reset
  // every window must restart from zero.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      cnt <= cnt_nxt;
    end
  end
`else
  // Debounce bypass: the stable bits follow the synchroniser directly.
  always_comb begin
    stable_nxt = s2;
  end
`endif

  // Accepted (debounced) level of every channel.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      stable <= RST_VAL;
    end else begin
      stable <= stable_nxt;
    end
  end

  // A press is the edge on which the key's accepted level falls from 1 to 0.
  // A release has no effect on sub_mode.
  assign press = stable[KEY_IDX] & ~stable_nxt[KEY_IDX];

  // Add/sub mode bit. It toggles once for each accepted press.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      sub_mode <= 1'b0;
    end else if (press) begin
      sub_mode <= ~sub_mode;
    end
  end

  // Outputs are plain wiring from registers. There is no path from the pins.
  assign in_port0    = {27'b0, stable[4:0]};
  assign in_port1    = {27'b0, stable[9:5]};
  assign in_port_sub = {31'b0, sub_mode};

endmodule

// File: tb/tb_io_switch_debounce.sv
// Testbench for io_switch_debounce.
// The reference model records the history of sampled pin values. A channel's
// accepted level flips only when every synchronised sample in the most recent
// window differs from the current accepted level. With debouncing enabled,
// the window is DB_CYCLES samples wide; in the bypass build it is one sample.
// A synchronised sample lags its pin sample by two edges.

module tb_io_switch_debounce;

  localparam int unsigned DB = 4;
`ifdef IO_DEBOUNCE_EN
  localparam int unsigned WIN = DB;
`else
  localparam int unsigned WIN = 1;
`endif
  localparam logic [10:0] RST_WORD = {1'b1, 10'b0};

  logic        io_clk;
  logic        resetn;
  logic [9:0]  sw;
  logic        key;
  logic [31:0] in_port0;
  logic [31:0] in_port1;
  logic [31:0] in_port_sub;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state.
  logic [10:0] hist[$];
  logic [10:0] m_stable;
  logic        m_sub;

  io_switch_debounce #(
    .DB_CYCLES (DB),
    .CNT_W     (3)
  ) dut (
    .io_clk      (io_clk),
    .resetn      (resetn),
    .sw          (sw),
    .key         (key),
    .in_port0    (in_port0),
    .in_port1    (in_port1),
    .in_port_sub (in_port_sub)
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < WIN + 2; i++) hist.push_back(RST_WORD);
    m_stable = RST_WORD;
    m_sub    = 1'b0;
  endtask

  // One rising edge: record the pin sample and apply the window rule.
  task automatic model_edge(input logic [10:0] smp);
    logic [10:0] nxt;
    bit          all_diff;
    hist.push_back(smp);
    nxt = m_stable;
    for (int b = 0; b < 11; b++) begin
      all_diff = 1'b1;
      // Entries 1..WIN hold the samples taken WIN+1 .. 2 edges ago.
      for (int j = 1; j <= WIN; j++) begin
        if (hist[j][b] == m_stable[b]) all_diff = 1'b0;
      end
      if (all_diff) nxt[b] = ~m_stable[b];
    end
    if (m_stable[10] && !nxt[10]) m_sub = ~m_sub;
    m_stable = nxt;
    void'(hist.pop_front());
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s @%0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    check("in_port0",    in_port0,    {27'b0, m_stable[4:0]});
    check("in_port1",    in_port1,    {27'b0, m_stable[9:5]});
    check("in_port_sub", in_port_sub, {31'b0, m_sub});
  endtask

  // Drive the pins, advance one rising edge, then check slightly after it.
  task automatic tick(input logic [9:0] sw_v, input logic key_v);
    sw  = sw_v;
    key = key_v;
    @(posedge io_clk);
    if (resetn) model_edge({key_v, sw_v});
    #1;
    check_all();
  endtask

  task automatic hold(input logic [9:0] sw_v, input logic key_v, input int n);
    for (int i = 0; i < n; i++) tick(sw_v, key_v);
  endtask

  task automatic assert_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    check_all();
  endtask

  initial begin
    logic [9:0] rsw;
    logic       rkey;

    resetn = 1'b1;
    sw     = 10'h3FF;
    key    = 1'b0;
    model_reset();
    #1;

    // Hold in reset with every switch high and the key pressed.
    assert_reset();
    hold(10'h3FF, 1'b0, 3);
    resetn = 1'b1;
    hold(10'h3FF, 1'b0, 6);

    // Settle latency for a two-bit pattern. The key stays pressed.
    hold(10'h005, 1'b0, 7);
    // Release the key. sub_mode must not change.
    hold(10'h005, 1'b1, 8);

    // Bounce on sw[0]: clear it first, then 1,0,1,0, then hold at 1.
    hold(10'h004, 1'b1, 7);
    tick(10'h005, 1'b1);
    tick(10'h004, 1'b1);
    tick(10'h005, 1'b1);
    tick(10'h004, 1'b1);
    hold(10'h005, 1'b1, 8);

    // Key toggles: long press, release, long press, release.
    hold(10'h005, 1'b0, 10);
    hold(10'h005, 1'b1, 10);
    hold(10'h005, 1'b0, 10);
    hold(10'h005, 1'b1, 10);
    // A short press and a single-cycle pulse, each followed by a release.
    hold(10'h005, 1'b0, 3);
    hold(10'h005, 1'b1, 10);
    hold(10'h005, 1'b0, 1);
    hold(10'h005, 1'b1, 10);

    // Reset in the middle of an sw[9] count, then release with sw held.
    hold(10'h205, 1'b1, 2);
    assert_reset();
    hold(10'h205, 1'b1, 2);
    resetn = 1'b1;
    hold(10'h205, 1'b1, 8);

    // Several switches change at once.
    hold(10'h3DA, 1'b1, 8);
    hold(10'h021, 1'b1, 8);

    // Random pin activity with random hold lengths.
    rsw  = 10'h0;
    rkey = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rsw = 10'($urandom);
      if ($urandom_range(0, 4) == 0) rkey = ~rkey;
      if ($urandom_range(0, 15) == 0) rsw[$urandom_range(0, 9)] ^= 1'b1;
      tick(rsw, rkey);
    end

    // Reset at a random point, then a quiet tail.
    assert_reset();
    hold(rsw, rkey, 2);
    resetn = 1'b1;
    hold(rsw, rkey, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
